// File: rtl/display_pkg.sv
// display_pkg: LCD geometry, frame-buffer widths and read_rectangle state encodings
package display_pkg;
    localparam int LCD_WIDTH     = 240;
    localparam int LCD_HEIGHT    = 320;
    localparam int FB_ADDR_WIDTH = 17;
    localparam int PIXEL_WIDTH   = 16;
    typedef enum logic [2:0] {IDLE, READ, WAIT, OUTPUT, FINISH} state_t;
endpackage

// File: rtl/read_rectangle_if.sv
// read_rectangle_if: command, frame-buffer RAM and pixel-stream signals of read_rectangle
interface read_rectangle_if;
    import display_pkg::*;
    logic                     start;
    logic [7:0]               xOrigin;
    logic [8:0]               yOrigin;
    logic [7:0]               width;
    logic [8:0]               height;
    logic                     ready;
    logic [FB_ADDR_WIDTH-1:0] ramAddress;
    logic                     ramRead;
    logic [PIXEL_WIDTH-1:0]   ramData;
    logic [PIXEL_WIDTH-1:0]   pixelData;
    logic [7:0]               pixelX;
    logic [8:0]               pixelY;
    logic                     pixelValid;
    logic                     pixelAck;
    logic                     done;
    modport master (output start, xOrigin, yOrigin, width, height, ramData, pixelAck,
                    input  ready, ramAddress, ramRead, pixelData, pixelX, pixelY, pixelValid, done);
    modport slave  (input  start, xOrigin, yOrigin, width, height, ramData, pixelAck,
                    output ready, ramAddress, ramRead, pixelData, pixelX, pixelY, pixelValid, done);
endinterface

// File: rtl/pixel_address.sv
// pixel_address: (x,y) to frame-buffer word address y*240+x via shift-subtract
module pixel_address (
    input  logic [7:0]  i_x,
    input  logic [8:0]  i_y,
    output logic [16:0] o_addr
);
    assign o_addr = {i_y, 8'b0} - {4'b0, i_y, 4'b0} + {9'b0, i_x};
endmodule

// File: rtl/read_rectangle.sv
// read_rectangle: streams a frame-buffer rectangle out row-major; READ_RECTANGLE_CLIP_EN skips off-screen pixels
module read_rectangle
    import display_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    read_rectangle_if.slave  bus
);
    state_t      r_state, w_next;
    logic [8:0]  r_x, r_x0, r_xl;
    logic [9:0]  r_y, r_y0, r_yl;
    logic [15:0] r_data;
    logic [7:0]  r_px;
    logic [8:0]  r_py;
    logic [16:0] w_addr;
    logic        w_on, w_last, w_eol, w_adv;

    pixel_address u_addr (.i_x(r_x[7:0]), .i_y(r_y[8:0]), .o_addr(w_addr));

    assign w_on   = (r_x < 9'(LCD_WIDTH)) && (r_y < 10'(LCD_HEIGHT));
    assign w_eol  = r_x == r_xl;
    assign w_last = w_eol && (r_y == r_yl);
`ifdef READ_RECTANGLE_CLIP_EN
    assign w_adv  = !w_last && ((r_state == OUTPUT && bus.pixelAck) || (r_state == READ && !w_on));
`else
    assign w_adv  = !w_last && r_state == OUTPUT && bus.pixelAck;
`endif

    assign bus.ready      = r_state == IDLE;
    assign bus.ramRead    = r_state == READ && w_on;
    assign bus.ramAddress = w_addr;
    assign bus.pixelValid = r_state == OUTPUT;
    assign bus.done       = r_state == FINISH;
    assign bus.pixelData  = r_data;
    assign bus.pixelX     = r_px;
    assign bus.pixelY     = r_py;

    // state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state: empty regions go straight to FINISH; off-screen pixels never read RAM
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (bus.start) w_next = (bus.width == 8'd0 || bus.height == 9'd0) ? FINISH : READ;
`ifdef READ_RECTANGLE_CLIP_EN
            READ:   w_next = w_on ? WAIT : (w_last ? FINISH : READ);
`else
            READ:   w_next = WAIT;
`endif
            WAIT:   w_next = OUTPUT;
            OUTPUT: if (bus.pixelAck) w_next = w_last ? FINISH : READ;
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // region latch, x-inner/y-outer counters and output pixel capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x    <= '0;
            r_x0   <= '0;
            r_xl   <= '0;
            r_y    <= '0;
            r_y0   <= '0;
            r_yl   <= '0;
            r_data <= '0;
            r_px   <= '0;
            r_py   <= '0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_x  <= {1'b0, bus.xOrigin};
                r_x0 <= {1'b0, bus.xOrigin};
                r_xl <= {1'b0, bus.xOrigin} + {1'b0, bus.width} - 9'd1;
                r_y  <= {1'b0, bus.yOrigin};
                r_y0 <= {1'b0, bus.yOrigin};
                r_yl <= {1'b0, bus.yOrigin} + {1'b0, bus.height} - 10'd1;
            end
            if (w_adv) begin
                r_x <= w_eol ? r_x0 : r_x + 9'd1;
                r_y <= w_eol ? r_y + 10'd1 : r_y;
            end
            if (r_state == WAIT) begin
                r_data <= w_on ? bus.ramData : 16'h0000;
                r_px   <= r_x[7:0];
                r_py   <= r_y[8:0];
            end
        end
    end
endmodule

// File: tb/tb_read_rectangle.sv
// tb_read_rectangle: randomized regions checked against a behavioural pixel/read scoreboard
module tb_read_rectangle;
    logic clock = 0;
    logic reset = 1;
    always #5 clock = ~clock;

    read_rectangle_if bus();
    read_rectangle dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {int x; int y; int d;} pix_t;
    pix_t exp_pix[$];
    int   exp_rd[$];
    int   rd_log[$];
    int   rd_cyc[$];
    int   vcyc[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   done_cnt = 0, done_cyc = 0, zero_cnt = 0, pix_cnt = 0;
    int   ack_mode = 0, hold = 0;
    bit   pending = 0;
    pix_t held;

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    // expected stream: row-major scan, RAM word = low 16 address bits, off-screen data 0
    task automatic model(int x0, int y0, int w, int h);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++) begin
                bit on = x < 240 && y < 320;
                pix_t p;
`ifdef READ_RECTANGLE_CLIP_EN
                if (!on) continue;
`endif
                p.x = x % 256;
                p.y = y % 512;
                p.d = on ? (y * 240 + x) % 65536 : 0;
                exp_pix.push_back(p);
                if (on) exp_rd.push_back(y * 240 + x);
            end
    endtask

    always @(posedge clock) cyc++;

    always @(posedge clock) bus.ramData <= bus.ramRead ? bus.ramAddress[15:0] : 16'($urandom);

    initial begin
        pix_t p;
        bus.pixelAck = 1;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.ramRead) begin
                    rd_log.push_back(int'(bus.ramAddress));
                    rd_cyc.push_back(cyc);
                    if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
                    else chk("read_addr", int'(bus.ramAddress), exp_rd.pop_front());
                end
                if (bus.pixelValid) begin
                    if (!pending) begin
                        vcyc.push_back(cyc);
                        pix_cnt++;
                        if (bus.pixelData == 16'h0) zero_cnt++;
                        if (exp_pix.size() == 0) chk("unexpected_pixel", 1, 0);
                        else begin
                            p = exp_pix.pop_front();
                            chk("pixel_x", int'(bus.pixelX), p.x);
                            chk("pixel_y", int'(bus.pixelY), p.y);
                            chk("pixel_data", int'(bus.pixelData), p.d);
                        end
                        held.x = int'(bus.pixelX);
                        held.y = int'(bus.pixelY);
                        held.d = int'(bus.pixelData);
                        hold = 0;
                    end else begin
                        chk("hold_x", int'(bus.pixelX), held.x);
                        chk("hold_y", int'(bus.pixelY), held.y);
                        chk("hold_data", int'(bus.pixelData), held.d);
                        hold++;
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
            bus.pixelAck = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? 1'($urandom_range(0, 1)) :
                           ack_mode == 2 ? (hold >= 5) : 1'b0;
            pending = bus.pixelValid && !bus.pixelAck && !reset;
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        rd_cyc.delete();
        vcyc.delete();
        zero_cnt = 0;
        pix_cnt = 0;
    endtask

    task automatic run(int x0, int y0, int w, int h, bit poke, output int t0);
        int d0, n;
        model(x0, y0, w, h);
        @(negedge clock); #1;
        chk("ready_before_start", int'(bus.ready), 1);
        bus.xOrigin = 8'(x0); bus.yOrigin = 9'(y0); bus.width = 8'(w); bus.height = 9'(h);
        bus.start = 1;
        t0 = cyc;
        d0 = done_cnt;
        @(negedge clock); #1;
        bus.start = poke && w > 0 && h > 0;
        bus.xOrigin = 8'($urandom); bus.yOrigin = 9'($urandom); bus.width = 8'($urandom); bus.height = 9'($urandom);
        @(negedge clock); #1;
        bus.start = 0;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clock); #1;
            n++;
        end
        chk("done_count", done_cnt - d0, 1);
        @(negedge clock); #1;
        chk("ready_after_done", int'(bus.ready), 1);
        chk("pixels_left", exp_pix.size(), 0);
        chk("reads_left", exp_rd.size(), 0);
        chk("no_extra_done", done_cnt - d0, 1);
    endtask

    initial begin
        int t0, d0, n;
        int lit[4] = '{4810, 4811, 5050, 5051};
        bus.start = 0; bus.xOrigin = 0; bus.yOrigin = 0; bus.width = 0; bus.height = 0;
        repeat (3) @(negedge clock);
        #1 reset = 0;
        @(negedge clock); #1;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_ramRead", int'(bus.ramRead), 0);
        chk("rst_valid", int'(bus.pixelValid), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_addr", int'(bus.ramAddress), 0);
        chk("rst_data", int'(bus.pixelData), 0);
        chk("rst_px", int'(bus.pixelX), 0);
        chk("rst_py", int'(bus.pixelY), 0);

        ack_mode = 0;
        clear_logs();
        run(10, 20, 2, 2, 0, t0);
        chk("t1_reads", rd_log.size(), 4);
        for (int i = 0; i < rd_log.size() && i < 4; i++) chk("t1_addr", rd_log[i], lit[i]);
        chk("t1_first_read_cyc", rd_cyc.size() > 0 ? rd_cyc[0] - t0 : -1, 1);
        chk("t1_pixels", vcyc.size(), 4);
        for (int i = 0; i < vcyc.size(); i++) chk("t1_valid_cyc", vcyc[i] - t0, 3 + 3 * i);
        chk("t1_done_cyc", done_cyc - t0, 13);

        clear_logs();
        run(5, 5, 0, 5, 0, t0);
        chk("empty_done_cyc", done_cyc - t0, 1);
        chk("empty_reads", rd_log.size(), 0);
        chk("empty_pixels", pix_cnt, 0);

        ack_mode = 2;
        clear_logs();
        run(50, 60, 3, 1, 0, t0);
        chk("slow_reads", rd_log.size(), 3);
        chk("slow_pixels", pix_cnt, 3);

        ack_mode = 1;
        clear_logs();
        run(238, 319, 4, 2, 0, t0);
`ifdef READ_RECTANGLE_CLIP_EN
        chk("edge_pixels", pix_cnt, 2);
        chk("edge_zero", zero_cnt, 0);
`else
        chk("edge_pixels", pix_cnt, 8);
        chk("edge_zero", zero_cnt, 6);
`endif
        chk("edge_reads", rd_log.size(), 2);

        ack_mode = 3;
        model(0, 0, 5, 5);
        @(negedge clock); #1;
        bus.xOrigin = 0; bus.yOrigin = 0; bus.width = 5; bus.height = 5; bus.start = 1;
        d0 = done_cnt;
        @(negedge clock); #1;
        bus.start = 0;
        n = 0;
        while (!bus.pixelValid && n < 50) begin
            @(negedge clock); #1;
            n++;
        end
        chk("rst_reach_output", int'(bus.pixelValid), 1);
        reset = 1;
        @(negedge clock); #1;
        chk("midrst_valid", int'(bus.pixelValid), 0);
        chk("midrst_ready", int'(bus.ready), 1);
        chk("midrst_data", int'(bus.pixelData), 0);
        reset = 0;
        exp_pix.delete();
        exp_rd.delete();
        repeat (4) @(negedge clock);
        #1 chk("midrst_no_done", done_cnt - d0, 0);
        ack_mode = 0;
        run(1, 1, 3, 2, 0, t0);

        clear_logs();
        run(30, 40, 3, 3, 1, t0);
        chk("poke_pixels", pix_cnt, 9);

        for (int k = 0; k < 25; k++) begin
            int x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(232, 255) : $urandom_range(0, 255);
            int y0 = ($urandom_range(0, 3) == 0) ? $urandom_range(314, 511) : $urandom_range(0, 511);
            ack_mode = $urandom_range(0, 1);
            run(x0, y0, $urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)), t0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/read_rectangle.md
# read_rectangle

Reads a rectangular region of the 240×320 16-bit LCD frame buffer and streams its pixels out in row-major order. It is the read-back counterpart of the square-drawing path: it takes the same origin/width/height description, issues frame-buffer RAM reads, and presents each pixel with its coordinates to a downstream consumer over a valid/ack handshake. It is used for screen capture, sprite save/restore and self-check of drawn shapes.

## Interface
- `LCD_WIDTH`, 240, display width in pixels (x range 0..239)
- `LCD_HEIGHT`, 320, display height in pixels (y range 0..319)
- `clock` input 1: single clock for all logic
- `reset` input 1: synchronous, active-high
- `start` input 1: begin a read; sampled only while `ready`=1
- `xOrigin` input 8: left column of region
- `yOrigin` input 9: top row of region
- `width` input 8: columns in region (0 = empty)
- `height` input 9: rows in region (0 = empty)
- `ready` output 1: idle, accepts `start`
- `ramAddress` output 17: frame-buffer word address = y*240 + x
- `ramRead` output 1: one-cycle read strobe
- `ramData` input 16: read data, valid the cycle after `ramRead`
- `pixelData` output 16: pixel value (RGB565)
- `pixelX` output 8, `pixelY` output 9: coordinates of `pixelData`
- `pixelValid` output 1: output pixel is valid
- `pixelAck` input 1: consumer accepts pixel when `pixelValid`&`pixelAck`
- `done` output 1: one-cycle pulse when region complete

## Operation
- States: IDLE, READ, WAIT, OUTPUT, FINISH.
- IDLE: `ready`=1. On `start`: latch origin/width/height, set x/y counters to origin. If `width`=0 or `height`=0 → FINISH, else → READ.
- READ: drive `ramAddress` from counters, `ramRead`=1 for exactly this cycle → WAIT.
- WAIT: capture `ramData` into `pixelData`, counters into `pixelX`/`pixelY` → OUTPUT.
- OUTPUT: `pixelValid`=1, outputs held stable until `pixelAck`. On ack: if last pixel → FINISH; else advance x (x inner loop); at end of row reset x to origin and increment y; → READ.
- FINISH: `done`=1 for one cycle → IDLE.
- Counters: x 9 bits, y 10 bits internally, so origin+extent never wraps. Last pixel is x = xOrigin+width-1, y = yOrigin+height-1.
- Address: y*240 + x computed as (y<<8) − (y<<4) + x, 17 bits, no overflow for in-display coordinates.
- `start` while not `ready` is ignored. Input changes after the start cycle have no effect.
- Reset in any state: → IDLE within the reset cycle, abandon the current region, no `done`.
- Reset values: `ready`=1 (after reset deasserts), `ramRead`=0, `pixelValid`=0, `done`=0, `ramAddress`=0, `pixelData`=0, `pixelX`=0, `pixelY`=0.

## Timing
- Start sampled at cycle 0 → `ready`=0 from cycle 1; `ramRead` in cycle 1; `pixelValid` in cycle 3.
- With `pixelAck` held high: 3 cycles per pixel (READ, WAIT, OUTPUT), next `ramRead` the cycle after ack.
- `done` asserts the cycle after the final ack. `ready`=1 the cycle after `done`.
- Empty region: `done` in cycle 1, `ready` in cycle 2, no `ramRead`, no `pixelValid`.
- Backpressure: unlimited stall in OUTPUT. No second read is outstanding.

## Configuration
- `READ_RECTANGLE_CLIP_EN` defined: pixels with x ≥ 240 or y ≥ 320 are skipped with no read and no output. They take one cycle each in READ without `ramRead`. A region fully off-screen produces only `done`.
- Undefined: off-screen pixels are still emitted in order with `pixelData`=16'h0000 and no `ramRead`, so the consumer always receives width×height pixels. `pixelX`/`pixelY` carry the low 8/9 bits of the coordinate.

## Structure
- Shared package `display_pkg`: LCD_WIDTH, LCD_HEIGHT, FB_ADDR_WIDTH=17, pixel width 16, state encodings.
- One sub-module, `pixel_address`: combinational (x,y) → 17-bit frame-buffer address using shift-subtract. It is reusable by the draw path.

## Test plan
- Start with origin (10,20), size 2×2, RAM model returning the address as data, ack always high → addresses 4810, 4811, 5050, 5051 in order. One pixel every 3 cycles. `done` 1 cycle after the 4th ack.
- `width`=0, `height`=5 → `done` in cycle 1, no `ramRead`, no `pixelValid`.
- 3×1 region, ack delayed 5 cycles per pixel → `pixelData`/`pixelX`/`pixelY` stable while valid. Exactly 3 `ramRead` pulses.
- Origin (238,319), size 4×2 → with CLIP_EN only (238,319) and (239,319) are emitted. Without it, 8 pixels are emitted, 6 of them data 0.
- Reset asserted while in OUTPUT of a 5×5 region → next cycle `pixelValid`=0, `ready`=1, no `done`. A new start runs normally.
- `start` pulsed again mid-region with different origin → ignored, original region completes unchanged.
